// File: rtl/reg_view_sequencer.sv
// rtl/reg_view_sequencer.sv - steps the register-file debug port and shows each register byte on the LED bank
//
// Fetches registers 0..NREG-1 one at a time over the debug read port. Each
// 32-bit value is latched into a shadow register, and its four bytes are shown
// on the LEDs in order (bits 7:0 first). The display advances when the dwell
// timer expires (auto_en=1) or when the step button gives a rising edge. A read
// that receives no rd_ack within TIMEOUT cycles is replaced with 32'hEEEE_EEEE,
// and the sticky err flag is set.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-low reset
//   auto_en   in   1 = dwell timer advances the display
//   step      in   asynchronous button level, each rising edge advances one byte
//   rd_req    out  read request to the register-file debug port
//   rd_addr   out  read address, always equal to cur_addr
//   rd_ack    in   one-cycle acknowledge, rd_data is valid in the same cycle
//   rd_data   in   register value
//   led       out  byte being displayed
//   cur_addr  out  register being displayed
//   cur_byte  out  byte lane being displayed (0 = bits 7:0)
//   err       out  sticky read-timeout flag
module reg_view_sequencer #(
  parameter int DWELL   = 50_000_000,
  parameter int TIMEOUT = 256,
  parameter int NREG    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        step,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic [7:0]  led,
  output logic [4:0]  cur_addr,
  output logic [1:0]  cur_byte,
  output logic        err
);

  localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    FETCH = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t        state, stateNext;
  logic          rdReqNext;
  logic [31:0]   shadow, shadowNext;
  logic [7:0]    ledNext;
  logic [4:0]    addrNext;
  logic [1:0]    byteNext;
  logic          errNext;
  logic [DW-1:0] dwellCnt, dwellNext;
  logic [TW-1:0] tmoCnt, tmoNext;

  // Two flops synchronize the button; s3 holds the previous synchronized level,
  // so that only a rising edge counts as a step.
  logic s1, s2, s3;
  logic stepEdge;
  logic dwellDone;
  logic advance;

  assign rd_addr   = cur_addr;
  assign stepEdge  = s2 & ~s3;
  assign dwellDone = auto_en && (dwellCnt == DW'(DWELL - 1));
  // A dwell expiry and a step edge in the same cycle merge into one advance.
  assign advance   = dwellDone | stepEdge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      rd_req   <= 1'b0;
      shadow   <= '0;
      led      <= '0;
      cur_addr <= '0;
      cur_byte <= '0;
      err      <= 1'b0;
      dwellCnt <= '0;
      tmoCnt   <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
    end else begin
      state    <= stateNext;
      rd_req   <= rdReqNext;
      shadow   <= shadowNext;
      led      <= ledNext;
      cur_addr <= addrNext;
      cur_byte <= byteNext;
      err      <= errNext;
      dwellCnt <= dwellNext;
      tmoCnt   <= tmoNext;
      s1       <= step;
      s2       <= s1;
      s3       <= s2;
    end
  end

  always_comb begin
    stateNext  = state;
    rdReqNext  = rd_req;
    shadowNext = shadow;
    ledNext    = led;
    addrNext   = cur_addr;
    byteNext   = cur_byte;
    errNext    = err;
    dwellNext  = dwellCnt;
    tmoNext    = tmoCnt;

    case (state)
      FETCH: begin
        // The request is raised one cycle after entering FETCH. An ack that
        // arrives before then belongs to no request and is ignored.
        // Step edges seen here are dropped.
        if (!rd_req) begin
          rdReqNext = 1'b1;
        end else if (rd_ack) begin
          shadowNext = rd_data;
          rdReqNext  = 1'b0;
          tmoNext    = '0;
          stateNext  = SHOW;
        end else if (tmoCnt == TW'(TIMEOUT - 1)) begin
          shadowNext = 32'hEEEE_EEEE;
          errNext    = 1'b1;
          rdReqNext  = 1'b0;
          tmoNext    = '0;
          stateNext  = SHOW;
        end else begin
          tmoNext = tmoCnt + TW'(1);
        end
      end

      SHOW: begin
        ledNext   = 8'(shadow >> {cur_byte, 3'b000});
        dwellNext = auto_en ? dwellCnt + DW'(1) : '0;
        if (advance) begin
          dwellNext = '0;
          if (cur_byte != 2'd3) begin
            byteNext = cur_byte + 2'd1;
          end else begin
            byteNext  = 2'd0;
            addrNext  = (cur_addr == 5'(NREG - 1)) ? 5'd0 : cur_addr + 5'd1;
            stateNext = FETCH;
          end
        end
      end

      default: stateNext = FETCH;
    endcase
  end

endmodule

// File: tb/tb_reg_view_sequencer.sv
// tb/tb_reg_view_sequencer.sv - self-checking bench for reg_view_sequencer
module tb_reg_view_sequencer;

  localparam int DWELL   = 4;
  localparam int TIMEOUT = 8;
  localparam int NREG    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        auto_en = 1'b0;
  logic        step = 1'b0;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic [7:0]  led;
  logic [4:0]  cur_addr;
  logic [1:0]  cur_byte;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_view_sequencer #(.DWELL(DWELL), .TIMEOUT(TIMEOUT), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .step(step),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .led(led), .cur_addr(cur_addr), .cur_byte(cur_byte), .err(err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reset pulse; returns at the falling edge just before the release edge.
  task automatic doReset();
    rst = 1'b0;
    rd_ack = 1'b0;
    step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Register-file responder: waits for rd_req, waits lat more cycles, then
  // acknowledges for one cycle. Returns at the falling edge after the ack edge.
  task automatic doRead(input logic [31:0] data, input int lat, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (rd_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rd_req !== 1'b1) return;
    repeat (lat) @(negedge clk);
    rd_ack = 1'b1;
    rd_data = data;
    @(negedge clk);
    rd_ack = 1'b0;
    rd_data = $urandom;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    auto_en = 1'b1;
    step = 1'b0;
    rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp 00", led); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got %b exp 0", rd_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (cur_addr !== 5'd0) begin errors++; $display("FAIL reset_cur_addr got %0d exp 0", cur_addr); end
    checks++; if (cur_byte !== 2'd0) begin errors++; $display("FAIL reset_cur_byte got %0d exp 0", cur_byte); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL reset_first_req got %b exp 1", rd_req); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_first_addr got %0d exp 0", rd_addr); end
  endtask

  // Auto mode: each byte is held DWELL cycles, then the next register is requested.
  task automatic test_auto_scan();
    logic [31:0] data;
    logic [7:0]  expLed;
    int lat;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      data = (r == 0) ? 32'h4433_2211 : $urandom;
      lat = (r == 0) ? 1 : $urandom_range(0, 4);
      checks++; if (rd_addr !== 5'(r)) begin errors++; $display("FAIL auto_rd_addr got %0d exp %0d", rd_addr, r); end
      doRead(data, lat, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL auto_req_wait got %b exp 1", ok); end
      for (int k = 0; k < 4 * DWELL; k++) begin
        @(negedge clk);
        expLed = 8'(data >> (8 * (k / DWELL)));
        checks++; if (led !== expLed) begin errors++; $display("FAIL auto_led reg %0d k %0d got %h exp %h", r, k, led, expLed); end
        checks++; if (cur_byte !== 2'(((k + 1) / DWELL) % 4)) begin errors++; $display("FAIL auto_cur_byte k %0d got %0d exp %0d", k, cur_byte, ((k + 1) / DWELL) % 4); end
        checks++; if (cur_addr !== 5'((k == 4 * DWELL - 1) ? r + 1 : r)) begin errors++; $display("FAIL auto_cur_addr k %0d got %0d", k, cur_addr); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL auto_req_low k %0d got %b exp 0", k, rd_req); end
      end
      @(negedge clk);
      checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL auto_req_again got %b exp 1", rd_req); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL auto_err got %b exp 0", err); end
  endtask

  // Manual step with exact synchronizer latency: advance at E+2, led at E+3.
  task automatic test_manual_step();
    logic [31:0] data;
    logic [7:0]  expLed;
    int w;
    int moved;
    bit ok;
    data = 32'hDEAD_BEEF;
    auto_en = 1'b0;
    doReset();
    doRead(data, $urandom_range(0, 3), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL manual_req_wait got %b exp 1", ok); end
    repeat (2) @(negedge clk);
    checks++; if (led !== 8'hEF) begin errors++; $display("FAIL manual_led0 got %h exp ef", led); end
    moved = 0;
    repeat (100) begin
      @(negedge clk);
      if (cur_byte !== 2'd0 || led !== 8'hEF) moved++;
    end
    checks++; if (moved !== 0) begin errors++; $display("FAIL manual_idle got %0d changed cycles exp 0", moved); end
    for (int p = 1; p <= 4; p++) begin
      w = $urandom_range(1, 3);
      step = 1'b1;
      @(negedge clk);
      if (w == 1) step = 1'b0;
      @(negedge clk);
      if (w == 2) step = 1'b0;
      checks++; if (cur_byte !== 2'(p - 1)) begin errors++; $display("FAIL manual_early pulse %0d got %0d exp %0d", p, cur_byte, p - 1); end
      @(negedge clk);
      step = 1'b0;
      checks++; if (cur_byte !== 2'(p % 4)) begin errors++; $display("FAIL manual_byte pulse %0d got %0d exp %0d", p, cur_byte, p % 4); end
      checks++; if (cur_addr !== 5'((p == 4) ? 1 : 0)) begin errors++; $display("FAIL manual_addr pulse %0d got %0d", p, cur_addr); end
      @(negedge clk);
      expLed = 8'(data >> (8 * ((p == 4) ? 3 : p)));
      checks++; if (led !== expLed) begin errors++; $display("FAIL manual_led pulse %0d got %h exp %h", p, led, expLed); end
      if (p == 4) begin
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL manual_fetch got %b exp 1", rd_req); end
        checks++; if (rd_addr !== 5'd1) begin errors++; $display("FAIL manual_rd_addr got %0d exp 1", rd_addr); end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  // Full scan past the last register back to address 0.
  task automatic test_wrap();
    bit ok;
    auto_en = 1'b1;
    doReset();
    for (int i = 0; i <= NREG; i++) begin
      checks++; if (rd_addr !== 5'(i % NREG)) begin errors++; $display("FAIL wrap_rd_addr read %0d got %0d exp %0d", i, rd_addr, i % NREG); end
      doRead($urandom, $urandom_range(0, 3), ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_req_wait read %0d got %b exp 1", i, ok); end
      repeat (4 * DWELL) @(negedge clk);
      checks++; if (cur_addr !== 5'((i + 1) % NREG) || cur_byte !== 2'd0) begin
        errors++; $display("FAIL wrap_next read %0d got addr %0d byte %0d exp addr %0d byte 0", i, cur_addr, cur_byte, (i + 1) % NREG);
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", err); end
  endtask

  // No ack: rd_req is high for exactly TIMEOUT cycles, EE is displayed, err is sticky.
  task automatic test_timeout();
    logic [31:0] data;
    logic [7:0]  expLed;
    int cnt;
    bit ok;
    auto_en = 1'b1;
    doReset();
    @(negedge clk);
    cnt = 0;
    while (rd_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt !== TIMEOUT) begin errors++; $display("FAIL tmo_req_cycles got %0d exp %0d", cnt, TIMEOUT); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", err); end
    for (int k = 0; k < 4 * DWELL; k++) begin
      @(negedge clk);
      checks++; if (led !== 8'hEE) begin errors++; $display("FAIL tmo_led k %0d got %h exp ee", k, led); end
    end
    @(negedge clk);
    checks++; if (rd_addr !== 5'd1) begin errors++; $display("FAIL tmo_next_addr got %0d exp 1", rd_addr); end
    data = $urandom;
    doRead(data, $urandom_range(0, 3), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_req_wait got %b exp 1", ok); end
    for (int k = 0; k < 4 * DWELL; k++) begin
      @(negedge clk);
      expLed = 8'(data >> (8 * (k / DWELL)));
      checks++; if (led !== expLed) begin errors++; $display("FAIL tmo_next_led k %0d got %h exp %h", k, led, expLed); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %b exp 1", err); end
  endtask

  // Step edge coinciding with dwell expiry, then a step edge dropped during FETCH.
  task automatic test_simultaneous();
    logic [31:0] data;
    int expByte;
    int n;
    bit ok;
    auto_en = 1'b1;
    doReset();
    data = $urandom;
    doRead(data, $urandom_range(0, 3), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sim_req_wait got %b exp 1", ok); end
    repeat (DWELL - 3) @(negedge clk);
    step = 1'b1;
    for (int j = DWELL - 2; j <= 2 * DWELL; j++) begin
      @(negedge clk);
      if (j == DWELL) step = 1'b0;
      expByte = (j >= 2 * DWELL) ? 2 : ((j >= DWELL) ? 1 : 0);
      checks++; if (cur_byte !== 2'(expByte)) begin errors++; $display("FAIL sim_byte j %0d got %0d exp %0d", j, cur_byte, expByte); end
    end
    n = 0;
    while (rd_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL sim_fetch_wait got %b exp 1", rd_req); end
    auto_en = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    data = $urandom;
    rd_ack = 1'b1;
    rd_data = data;
    @(negedge clk);
    rd_ack = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (cur_byte !== 2'd0) begin errors++; $display("FAIL sim_fetch_step_byte got %0d exp 0", cur_byte); end
    checks++; if (led !== data[7:0]) begin errors++; $display("FAIL sim_fetch_step_led got %h exp %h", led, data[7:0]); end
    checks++; if (cur_addr !== 5'd1) begin errors++; $display("FAIL sim_fetch_step_addr got %0d exp 1", cur_addr); end
  endtask

  // Reset while a read is pending; a late ack must not be taken.
  task automatic test_reset_mid_fetch();
    logic [31:0] data;
    int n;
    bit ok;
    auto_en = 1'b1;
    doReset();
    data = $urandom | 32'h0100_0000;
    doRead(data, $urandom_range(0, 3), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmf_req_wait got %b exp 1", ok); end
    n = 0;
    while (rd_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rd_req !== 1'b1 || cur_addr !== 5'd1) begin errors++; $display("FAIL rmf_pending got req %b addr %0d exp req 1 addr 1", rd_req, cur_addr); end
    checks++; if (led !== data[31:24]) begin errors++; $display("FAIL rmf_led_before got %h exp %h", led, data[31:24]); end
    rst = 1'b0;
    rd_ack = 1'b1;
    rd_data = 32'h1234_5678;
    @(negedge clk);
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL rmf_req_drop got %b exp 0", rd_req); end
    checks++; if (cur_addr !== 5'd0) begin errors++; $display("FAIL rmf_addr got %0d exp 0", cur_addr); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL rmf_led got %h exp 00", led); end
    rst = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL rmf_late_ack got req %b exp 1", rd_req); end
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h00 || cur_byte !== 2'd0) begin errors++; $display("FAIL rmf_still_fetch got led %h byte %0d exp 00 0", led, cur_byte); end
    data = $urandom;
    doRead(data, 0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmf_new_read got %b exp 1", ok); end
    @(negedge clk);
    checks++; if (led !== data[7:0]) begin errors++; $display("FAIL rmf_new_led got %h exp %h", led, data[7:0]); end
  endtask

  initial begin
    test_reset();
    test_auto_scan();
    test_manual_step();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
